// File: rtl/mcu_cycle_timer.sv
// Machine-cycle timing controller: sequences S1P1..S6P2 from a prescaled clock,
// with wait-state stretching, idle entry/exit and deferred prescale reloads.
module mcu_cycle_timer #(
    parameter int unsigned RESET_DIV = 0,
    parameter int unsigned DIV_W     = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             div_load,
    output logic             div_ack,
    input  logic             idle_req,
    input  logic             wake,
    input  logic             wait_req,
    output logic             phase_tick,
    output logic             mc_start,
    output logic [2:0]       state,
    output logic             phase,
    output logic             idle
);

    localparam logic       FSM_RUN    = 1'b0;
    localparam logic       FSM_IDLE   = 1'b1;
    localparam logic [2:0] LAST_STATE = 3'd5;

    logic             fsm;
    logic [DIV_W-1:0] pre_cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_pend;
    logic             pend_flag;
    logic             tick;
    logic             boundary;

    always_comb begin
        tick     = (fsm == FSM_RUN) && (pre_cnt == div_q);
        boundary = tick && (state == LAST_STATE) && phase;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            fsm        <= FSM_RUN;
            pre_cnt    <= '0;
            div_q      <= DIV_W'(RESET_DIV);
            div_pend   <= '0;
            pend_flag  <= 1'b0;
            state      <= LAST_STATE;
            phase      <= 1'b1;
            phase_tick <= 1'b0;
            mc_start   <= 1'b0;
            div_ack    <= 1'b0;
            idle       <= 1'b0;
        end else begin
            phase_tick <= 1'b0;
            mc_start   <= 1'b0;
            div_ack    <= 1'b0;
            if (fsm == FSM_IDLE) begin
                pre_cnt <= '0;
                if (div_load) begin
                    div_q   <= div_cfg;
                    div_ack <= 1'b1;
                end
                if (wake) begin
                    fsm  <= FSM_RUN;
                    idle <= 1'b0;
                end
            end else begin
                pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                if (boundary) begin
                    // A load arriving on the boundary itself beats an older pending value.
                    if (div_load)
                        div_q <= div_cfg;
                    else if (pend_flag)
                        div_q <= div_pend;
                    pend_flag <= 1'b0;
                    div_ack   <= div_load | pend_flag;
                    if (idle_req) begin
                        fsm  <= FSM_IDLE;
                        idle <= 1'b1;
                    end else if (!wait_req) begin
                        state      <= '0;
                        phase      <= 1'b0;
                        phase_tick <= 1'b1;
                        mc_start   <= 1'b1;
                    end
                end else begin
                    if (div_load) begin
                        div_pend  <= div_cfg;
                        pend_flag <= 1'b1;
                    end
                    if (tick) begin
                        phase_tick <= 1'b1;
                        if (phase) begin
                            state <= state + 3'd1;
                            phase <= 1'b0;
                        end else begin
                            phase <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mcu_cycle_timer.sv
// Directed bench for mcu_cycle_timer: phase walk, prescale reloads, waits,
// idle entry/exit and reset during a pending load.
module tb_mcu_cycle_timer;

    logic       clk_in = 1'b0;
    logic       rst;
    logic [3:0] div_cfg;
    logic       div_load;
    logic       div_ack;
    logic       idle_req;
    logic       wake;
    logic       wait_req;
    logic       phase_tick;
    logic       mc_start;
    logic [2:0] state;
    logic       phase;
    logic       idle;

    int checks = 0;
    int errors = 0;

    mcu_cycle_timer #(.RESET_DIV(0), .DIV_W(4)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .div_cfg    (div_cfg),
        .div_load   (div_load),
        .div_ack    (div_ack),
        .idle_req   (idle_req),
        .wake       (wake),
        .wait_req   (wait_req),
        .phase_tick (phase_tick),
        .mc_start   (mc_start),
        .state      (state),
        .phase      (phase),
        .idle       (idle)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(state), 32'd5);
        check({tag, "_phase"}, 32'(phase), 32'd1);
        check({tag, "_idle"}, 32'(idle), 32'd0);
        check({tag, "_tick"}, 32'(phase_tick), 32'd0);
        check({tag, "_mc"}, 32'(mc_start), 32'd0);
        check({tag, "_ack"}, 32'(div_ack), 32'd0);
    endtask

    initial begin
        int n;
        int ticks;
        int mcs;
        int acks;
        int bad;
        int s6;
        int first_mc;

        rst = 1'b1; div_cfg = '0; div_load = 1'b0;
        idle_req = 1'b0; wake = 1'b0; wait_req = 1'b0;
        repeat (3) step();
        check_reset_vals("reset");

        // 1: RESET_DIV=0 free run
        rst = 1'b0;
        ticks = 0; mcs = 0; bad = 0;
        for (int i = 1; i <= 25; i++) begin
            int k;
            step();
            k = (i - 1) % 12;
            if (phase_tick) ticks++;
            if (mc_start) begin
                mcs++;
                if (!(i == 1 || i == 13 || i == 25)) bad++;
            end
            if (state !== 3'(k / 2) || phase !== 1'(k % 2)) bad++;
        end
        check("t1_walk_bad", 32'(bad), 32'd0);
        check("t1_ticks", 32'(ticks), 32'd25);
        check("t1_mc_count", 32'(mcs), 32'd3);

        // 2: two loads in one machine cycle, last wins with one ack
        repeat (4) step();
        check("t2_state_at_load1", 32'(state), 32'd2);
        div_cfg = 4'd2; div_load = 1'b1; step(); div_load = 1'b0;
        check("t2_no_early_ack", 32'(div_ack), 32'd0);
        repeat (3) step();
        check("t2_state_at_load2", 32'(state), 32'd4);
        div_cfg = 4'd3; div_load = 1'b1; step(); div_load = 1'b0;
        acks = 0;
        for (int i = 10; i <= 12; i++) begin
            step();
            if (div_ack) acks++;
        end
        check("t2_boundary_mc", 32'(mc_start), 32'd1);
        check("t2_boundary_ack", 32'(div_ack), 32'd1);
        check("t2_ack_count", 32'(acks), 32'd1);
        ticks = 0; mcs = 0; acks = 0; bad = 0;
        for (int i = 1; i <= 48; i++) begin
            step();
            if (phase_tick) begin
                ticks++;
                if (i % 4 != 0) bad++;
            end
            if (div_ack) acks++;
            if (mc_start && i != 48) mcs++;
        end
        check("t2_mc_at_48", 32'(mc_start), 32'd1);
        check("t2_early_mc", 32'(mcs), 32'd0);
        check("t2_ticks", 32'(ticks), 32'd12);
        check("t2_tick_spacing_bad", 32'(bad), 32'd0);
        check("t2_extra_acks", 32'(acks), 32'd0);

        // 3: div_q=1 then wait_req across two boundaries
        div_cfg = 4'd1; div_load = 1'b1; step(); div_load = 1'b0;
        n = 0;
        for (int i = 0; i < 60 && !mc_start; i++) begin
            step();
            n++;
        end
        check("t3_reload_mc_at", 32'(n), 32'd47);
        check("t3_reload_ack", 32'(div_ack), 32'd1);
        wait_req = 1'b1;
        s6 = 0; ticks = 0; mcs = 0;
        for (int i = 1; i <= 28; i++) begin
            step();
            if (state == 3'd5 && phase) s6++;
            if (i >= 23 && i <= 27 && phase_tick) ticks++;
            if (i < 28 && mc_start) mcs++;
            if (i == 26) wait_req = 1'b0;
        end
        check("t3_s6p2_cycles", 32'(s6), 32'd6);
        check("t3_hold_ticks", 32'(ticks), 32'd0);
        check("t3_early_mc", 32'(mcs), 32'd0);
        check("t3_mc_at_28", 32'(mc_start), 32'd1);

        // 4: idle_req at S4, wake 10 cycles after idle
        repeat (12) step();
        check("t4_state_at_req", 32'(state), 32'd3);
        idle_req = 1'b1;
        n = 0;
        for (int i = 0; i < 30 && !idle; i++) begin
            step();
            n++;
        end
        idle_req = 1'b0;
        check("t4_idle_after", 32'(n), 32'd12);
        check("t4_idle_tick", 32'(phase_tick), 32'd0);
        check("t4_idle_mc", 32'(mc_start), 32'd0);
        ticks = 0;
        wake = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (phase_tick || mc_start || !idle) ticks++;
        end
        check("t4_idle_quiet", 32'(ticks), 32'd0);
        check("t4_idle_state", 32'({state, phase}), 32'd11);
        wake = 1'b1; step(); wake = 1'b0;
        check("t4_idle_fall", 32'(idle), 32'd0);
        step();
        check("t4_mc_not_yet", 32'(mc_start), 32'd0);
        step();
        check("t4_mc_after_2", 32'(mc_start), 32'd1);

        // 5: load while idle, then wake with div_q=4
        idle_req = 1'b1;
        n = 0;
        for (int i = 0; i < 30 && !idle; i++) begin
            step();
            n++;
        end
        idle_req = 1'b0;
        check("t5_idle_after", 32'(n), 32'd24);
        div_cfg = 4'd4; div_load = 1'b1; step(); div_load = 1'b0;
        check("t5_idle_ack", 32'(div_ack), 32'd1);
        step();
        check("t5_ack_single", 32'(div_ack), 32'd0);
        wake = 1'b1; step(); wake = 1'b0;
        check("t5_exit", 32'(idle), 32'd0);
        n = 0;
        for (int i = 0; i < 20 && !mc_start; i++) begin
            step();
            n++;
        end
        check("t5_mc_after_exit", 32'(n), 32'd5);

        // 6: idle_req + wait_req + div_load on the same boundary
        n = 0;
        for (int i = 0; i < 80 && !(state == 3'd5 && phase); i++) begin
            step();
            n++;
        end
        check("t6_reach_s6p2", 32'(n), 32'd55);
        repeat (4) step();
        check("t6_pre_boundary_tick", 32'(phase_tick), 32'd0);
        idle_req = 1'b1; wait_req = 1'b1; div_cfg = 4'd5; div_load = 1'b1;
        step();
        idle_req = 1'b0; wait_req = 1'b0; div_load = 1'b0;
        check("t6_ack", 32'(div_ack), 32'd1);
        check("t6_idle", 32'(idle), 32'd1);
        check("t6_no_mc", 32'(mc_start), 32'd0);
        wake = 1'b1; step(); wake = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !mc_start; i++) begin
            step();
            n++;
        end
        check("t6_div5_mc_after_exit", 32'(n), 32'd6);

        // Reset while a load is pending discards it
        repeat (2) step();
        div_cfg = 4'd1; div_load = 1'b1; step(); div_load = 1'b0;
        check("rst_pend_no_ack", 32'(div_ack), 32'd0);
        rst = 1'b1; step();
        check_reset_vals("midrst");
        step();
        rst = 1'b0;
        acks = 0; mcs = 0; first_mc = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (div_ack) acks++;
            if (mc_start) begin
                mcs++;
                if (first_mc == 0) first_mc = i;
            end
        end
        check("rst_no_ack", 32'(acks), 32'd0);
        check("rst_first_mc", 32'(first_mc), 32'd1);
        check("rst_mc_count", 32'(mcs), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
